// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch port and the data port through a grant FSM with a watchdog abort.
// Optional build macro MEMARB_RR_EN: round-robin arbitration instead of fixed data-over-fetch priority.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready_n,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready_n,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready_n,
  input  logic        m_busy,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUS_I = 2'd1;
  localparam logic [1:0] BUS_D = 2'd2;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] wd_cnt;
  logic       in_bus;
  logic       ack;
  logic       abort;
  logic       done;
  logic       grant_any;
  logic       grant_d;
  logic       prio_d;

  assign in_bus    = (state == BUS_I) || (state == BUS_D);
  assign ack       = in_bus && !m_ready_n;
  // The abort fires on the last allowed cycle, so the owner still completes that cycle.
  assign abort     = in_bus && m_ready_n && (wd_cnt == TIMEOUT_LAST);
  assign done      = ack || abort;
  assign grant_any = (state == IDLE) && !m_busy && (if_req || d_req);
  assign grant_d   = d_req && (!if_req || prio_d);

`ifdef MEMARB_RR_EN
  logic last_grant_d;

  // Data wins a tie only if the fetch port was the last one served.
  assign prio_d = !last_grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_d <= 1'b0;
    end else if (grant_any) begin
      last_grant_d <= grant_d;
    end
  end
`else
  assign prio_d = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wd_cnt  <= 8'd0;
      m_req   <= 1'b0;
      m_write <= 1'b0;
      m_size  <= 2'd0;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state   <= grant_d ? BUS_D : BUS_I;
            wd_cnt  <= 8'd0;
            m_req   <= 1'b1;
            m_write <= grant_d && d_write;
            m_size  <= grant_d ? d_size : 2'd2;
            m_addr  <= grant_d ? d_addr : if_addr;
            m_wdata <= grant_d ? d_wdata : 32'd0;
          end
        end
        BUS_I, BUS_D: begin
          if (done) begin
            state  <= IDLE;
            m_req  <= 1'b0;
            wd_cnt <= 8'd0;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every output gets a default first so the combinational block cannot infer a latch.
  always_comb begin
    if_ready_n = 1'b1;
    if_rdata   = 32'd0;
    d_ready_n  = 1'b1;
    d_rdata    = 32'd0;
    err        = abort;
    if (done) begin
      if (state == BUS_I) begin
        if_ready_n = 1'b0;
        if_rdata   = ack ? m_rdata : 32'd0;
      end else if (state == BUS_D) begin
        d_ready_n = 1'b0;
        d_rdata   = ack ? m_rdata : 32'd0;
      end
    end
  end

endmodule
